// File: rtl/inst_encoder_loader.sv
// Instruction-memory loader: accepts symbolic RV32I commands over valid/ready, encodes each
// into a 32-bit word and writes it to consecutive imem words. Keeps the core in reset while
// loading and releases it when an END command arrives.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   cmd_valid / cmd_ready   command handshake (ready only while idle)
//   cmd_op/rd/rs1/rs2/imm   symbolic command (op 0..6 = ADD,SUB,AND,OR,LW,SW,BEQ; 7 = END)
//   imem_we/addr/wdata      one-cycle write strobe with word address and encoded instruction
//   core_hold               1 while loading or after an error
//   done                    program complete, core released
//   err / err_code          sticky error; 01 bad immediate, 10 memory full
//   count                   number of words written so far
module inst_encoder_loader #(
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_rs1,
  input  logic [4:0]        cmd_rs2,
  input  logic [12:0]       cmd_imm,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_hold,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpAnd = 3'd2;
  localparam logic [2:0] OpOr  = 3'd3;
  localparam logic [2:0] OpLw  = 3'd4;
  localparam logic [2:0] OpSw  = 3'd5;
  localparam logic [2:0] OpBeq = 3'd6;
  localparam logic [2:0] OpEnd = 3'd7;

  localparam logic [6:0] OpcR      = 7'b0110011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  localparam logic [ADDR_W:0] FullCount = DEPTH[ADDR_W:0];

  typedef enum logic [1:0] {StIdle, StWrite, StDone, StErr} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [1:0]        err_code_q, err_code_d;

  logic [31:0] enc;
  logic        imm_ok;
  logic        full;

  // Combinational encoder for the currently presented command.
  always_comb begin
    enc = '0;
    unique case (cmd_op)
      OpAdd:   enc = {7'b0000000, cmd_rs2, cmd_rs1, 3'b000, cmd_rd, OpcR};
      OpSub:   enc = {7'b0100000, cmd_rs2, cmd_rs1, 3'b000, cmd_rd, OpcR};
      OpAnd:   enc = {7'b0000000, cmd_rs2, cmd_rs1, 3'b111, cmd_rd, OpcR};
      OpOr:    enc = {7'b0000000, cmd_rs2, cmd_rs1, 3'b110, cmd_rd, OpcR};
      OpLw:    enc = {cmd_imm[11:0], cmd_rs1, 3'b010, cmd_rd, OpcLoad};
      OpSw:    enc = {cmd_imm[11:5], cmd_rs2, cmd_rs1, 3'b010, cmd_imm[4:0], OpcStore};
      OpBeq:   enc = {cmd_imm[12], cmd_imm[10:5], cmd_rs2, cmd_rs1, 3'b000, cmd_imm[4:1],
                      cmd_imm[11], OpcBranch};
      OpEnd:   enc = '0;
      default: enc = '0;
    endcase
  end

  // LW/SW offsets must fit 12-bit signed; branch offsets must be halfword aligned.
  always_comb begin
    imm_ok = 1'b1;
    if (cmd_op == OpLw || cmd_op == OpSw) imm_ok = (cmd_imm[12] == cmd_imm[11]);
    else if (cmd_op == OpBeq)             imm_ok = ~cmd_imm[0];
  end

  assign full = (count_q == FullCount);

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    err_code_d = err_code_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          if (cmd_op == OpEnd) begin
            state_d = StDone;
          end else if (full) begin
            state_d    = StErr;
            err_code_d = 2'b10;
          end else if (!imm_ok) begin
            state_d    = StErr;
            err_code_d = 2'b01;
          end else begin
            addr_d  = count_q[ADDR_W-1:0];
            wdata_d = enc;
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        count_d = count_q + (ADDR_W + 1)'(1);
        state_d = StIdle;
      end
      StDone:  state_d = StDone;
      StErr:   state_d = StErr;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      count_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_code_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_code_q <= err_code_d;
    end
  end

  assign cmd_ready  = (state_q == StIdle);
  assign imem_we    = (state_q == StWrite);
  assign imem_addr  = addr_q;
  assign imem_wdata = wdata_q;
  assign core_hold  = (state_q != StDone);
  assign done       = (state_q == StDone);
  assign err        = (state_q == StErr);
  assign err_code   = err_code_q;
  assign count      = count_q;

endmodule

// File: tb/tb_inst_encoder_loader.sv
// Bench for inst_encoder_loader: table of commands with hand-encoded expected words, a
// scoreboard queue popped on every write strobe, and directed error/full/reset sequences.
module tb_inst_encoder_loader;

  localparam int unsigned DEPTH  = 64;
  localparam int unsigned ADDR_W = 6;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [4:0]        cmd_rd;
  logic [4:0]        cmd_rs1;
  logic [4:0]        cmd_rs2;
  logic [12:0]       cmd_imm;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_hold;
  logic              done;
  logic              err;
  logic [1:0]        err_code;
  logic [ADDR_W:0]   count;

  inst_encoder_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_rd     (cmd_rd),
    .cmd_rs1    (cmd_rs1),
    .cmd_rs2    (cmd_rs2),
    .cmd_imm    (cmd_imm),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_hold  (core_hold),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .count      (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
    logic [31:0] exp;
  } vec_t;

  wr_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;
  int  exp_count;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, req, $time);
  endtask

  // Scoreboard: every strobe must match the oldest outstanding expected write.
  always @(negedge clk) begin
    if (imem_we) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_strobe: got addr 0x%0h data 0x%0h expected no write (t=%0t)",
                 imem_addr, imem_wdata, $time);
      end else begin
        wr_t w;
        w = exp_q.pop_front();
        chk("strobe_addr", 64'(imem_addr), 64'(w.addr));
        chk("strobe_data", 64'(imem_wdata), 64'(w.data));
      end
    end
  end

  task automatic do_reset();
    reset     = 1'b1;
    cmd_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    exp_count = 0;
  endtask

  // Waits (bounded) for ready, presents one command for one accept edge, returns at edge+1.
  task automatic send(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic [12:0] imm,
                      input logic expect_wr, input logic [31:0] exp_word);
    int k;
    k = 0;
    while (!cmd_ready && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!cmd_ready) begin
      chk("ready_timeout", 64'(cmd_ready), 64'd1);
      return;
    end
    if (expect_wr) begin
      wr_t w;
      w.addr = exp_count[ADDR_W-1:0];
      w.data = exp_word;
      exp_q.push_back(w);
      exp_count++;
    end
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    cmd_imm   = imm;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic fill_memory();
    for (int i = 0; i < int'(DEPTH); i++) begin
      send(3'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 32'h002081B3);
      @(posedge clk);
      #1;
    end
    chk("full_count", 64'(count), 64'(DEPTH));
  endtask

  vec_t vecs[10];

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = '0;
    cmd_rd    = '0;
    cmd_rs1   = '0;
    cmd_rs2   = '0;
    cmd_imm   = '0;
    exp_count = 0;

    vecs[0] = '{3'd0, 5'd3, 5'd1, 5'd2, 13'h0000, 32'h002081B3}; // ADD 3,1,2
    vecs[1] = '{3'd1, 5'd3, 5'd1, 5'd2, 13'h0000, 32'h402081B3}; // SUB 3,1,2
    vecs[2] = '{3'd2, 5'd4, 5'd1, 5'd2, 13'h0000, 32'h0020F233}; // AND 4,1,2
    vecs[3] = '{3'd3, 5'd5, 5'd1, 5'd2, 13'h1ABC, 32'h0020E2B3}; // OR 5,1,2 (imm ignored)
    vecs[4] = '{3'd4, 5'd5, 5'd0, 5'd0, 13'h0008, 32'h00802283}; // LW x5, 8(x0)
    vecs[5] = '{3'd5, 5'd0, 5'd0, 5'd5, 13'h000C, 32'h00502623}; // SW x5, 12(x0)
    vecs[6] = '{3'd6, 5'd0, 5'd1, 5'd2, 13'h1FF8, 32'hFE208CE3}; // BEQ x1,x2,-8
    vecs[7] = '{3'd4, 5'd1, 5'd2, 5'd0, 13'h1FFC, 32'hFFC12083}; // LW x1, -4(x2)
    vecs[8] = '{3'd5, 5'd9, 5'd4, 5'd3, 13'h1FFF, 32'hFE322FA3}; // SW x3, -1(x4), rd ignored
    vecs[9] = '{3'd6, 5'd0, 5'd3, 5'd4, 13'h0010, 32'h00418863}; // BEQ x3,x4,+16

    do_reset();
    chk("rst_ready", 64'(cmd_ready), 64'd1);
    chk("rst_we", 64'(imem_we), 64'd0);
    chk("rst_addr_wdata", {26'd0, imem_addr, imem_wdata}, 64'd0);
    chk("rst_hold", 64'(core_hold), 64'd1);
    chk("rst_done_err", {61'd0, done, err_code}, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_count", 64'(count), 64'd0);

    for (int i = 0; i < 10; i++) begin
      send(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, 1'b1, vecs[i].exp);
      chk("we_after_accept", 64'(imem_we), 64'd1);
      chk("busy_ready", 64'(cmd_ready), 64'd0);
      @(posedge clk);
      #1;
      chk("we_one_cycle", 64'(imem_we), 64'd0);
      chk("count_step", 64'(count), 64'(i + 1));
    end

    // END releases the core; further commands are not accepted.
    send(3'd7, 5'd0, 5'd0, 5'd0, 13'd0, 1'b0, 32'd0);
    chk("end_done", 64'(done), 64'd1);
    chk("end_hold", 64'(core_hold), 64'd0);
    chk("end_ready", 64'(cmd_ready), 64'd0);
    cmd_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("end_terminal", {62'd0, done, err}, 64'd2);

    // LW immediate out of 12-bit range.
    do_reset();
    send(3'd4, 5'd5, 5'd0, 5'd0, 13'h0800, 1'b0, 32'd0);
    chk("badimm_lw_err", 64'(err), 64'd1);
    chk("badimm_lw_code", 64'(err_code), 64'd1);
    chk("badimm_lw_ready", 64'(cmd_ready), 64'd0);
    chk("badimm_lw_hold", 64'(core_hold), 64'd1);
    cmd_op    = 3'd0;
    cmd_valid = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
      chk("err_no_we", 64'(imem_we), 64'd0);
    end
    cmd_valid = 1'b0;
    chk("err_count", 64'(count), 64'd0);

    // BEQ odd offset.
    do_reset();
    send(3'd6, 5'd0, 5'd1, 5'd2, 13'h0003, 1'b0, 32'd0);
    chk("badimm_beq_code", {61'd0, err, err_code}, 64'h5);
    chk("badimm_beq_we", 64'(imem_we), 64'd0);

    // Fill memory, then one more ADD overflows.
    do_reset();
    fill_memory();
    send(3'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b0, 32'd0);
    chk("full_err", 64'(err), 64'd1);
    chk("full_code", 64'(err_code), 64'd2);
    @(posedge clk);
    #1;
    chk("full_no_we", 64'(imem_we), 64'd0);

    // Fill memory, then END is still legal.
    do_reset();
    fill_memory();
    send(3'd7, 5'd0, 5'd0, 5'd0, 13'd0, 1'b0, 32'd0);
    chk("full_end_done", {62'd0, done, core_hold}, 64'd2);
    chk("full_end_err", 64'(err), 64'd0);

    // Reset during the write cycle: strobe of that cycle only, nothing after the reset edge.
    do_reset();
    send(3'd0, 5'd3, 5'd1, 5'd2, 13'd0, 1'b1, 32'h002081B3);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_we", 64'(imem_we), 64'd0);
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_hold", 64'(core_hold), 64'd1);
    chk("midrst_ready", 64'(cmd_ready), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_quiet", 64'(imem_we), 64'd0);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got still running expected finished");
    $fatal(1, "timeout");
  end

endmodule
